// File: rtl/mu0_mem_pkg.sv
// mu0_mem_pkg: shared constants for the mu0 memory subsystem.
// Holds the FSM state encoding and default AW/DW/DEPTH values.
package mu0_mem_pkg;

    localparam int AW_DEF    = 12;
    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 4096;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/mu0_ram.sv
// mu0_ram: DEPTH x DW word RAM, one synchronous write port and one
// asynchronous read port.
// Ports: clk_i, we_i, waddr_i, wdata_i (write); raddr_i -> rdata_o (read).
module mu0_ram #(
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int DEPTH = 4096
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mu0_mem_sys.sv
// mu0_mem_sys: boot loader + zero-wait RAM for the mu0 core, with a
// LOAD/RUN/HALT FSM. Optional macro MU0_MEM_WRITE_PROTECT_EN adds wp_err.
// Ports: clk, rst (sync, active-high); boot stream ld_valid/ld_data/
// ld_last/ld_ready; core bus addr/MEMrq/RnW/STP_flag/mem_din;
// outputs mem_dout/mem_dout_oe, cpu_rst_n, state_o, ld_count[, wp_err].
module mu0_mem_sys
    import mu0_mem_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_rst_n,
    input  logic [AW-1:0] addr,
    input  logic          MEMrq,
    input  logic          RnW,
    input  logic          STP_flag,
    input  logic [DW-1:0] mem_din,
    output logic [DW-1:0] mem_dout,
    output logic          mem_dout_oe,
`ifdef MU0_MEM_WRITE_PROTECT_EN
    output logic          wp_err,
`endif
    output logic [1:0]    state_o,
    output logic [AW:0]   ld_count
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e        state_q;
    logic [AW:0]   ptr_q;
    logic          cpu_rst_n_q;

    logic          in_range;
    logic          ld_acc;
    logic          core_rd;
    logic          core_wr_req;
    logic          core_wr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    assign in_range = {1'b0, addr} < DEPTH_W;

    // Handshake outputs are gated by rst so they read 0 in the reset cycle.
    assign ld_ready = !rst && (state_q == ST_LOAD) && (ptr_q < DEPTH_W);
    assign ld_acc   = ld_valid && ld_ready;

    assign core_rd     = !rst && (state_q == ST_RUN) && MEMrq && RnW;
    assign core_wr_req = !rst && (state_q == ST_RUN) && MEMrq && !RnW
                         && in_range;

`ifdef MU0_MEM_WRITE_PROTECT_EN
    logic wp_hit;
    logic wp_err_q;

    // ptr_q holds the loaded word count while running.
    assign wp_hit  = {1'b0, addr} < ptr_q;
    assign core_wr = core_wr_req && !wp_hit;
    assign wp_err  = wp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_err_q <= 1'b0;
        end else if (core_wr_req && wp_hit) begin
            wp_err_q <= 1'b1;
        end
    end
`else
    assign core_wr = core_wr_req;
`endif

    // Loader and core never write in the same cycle (different states).
    assign ram_we    = ld_acc || core_wr;
    assign ram_waddr = ld_acc ? ptr_q[AW-1:0] : addr;
    assign ram_wdata = ld_acc ? ld_data : mem_din;

    mu0_ram #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (addr),
        .rdata_o (ram_rdata)
    );

    assign mem_dout    = (core_rd && in_range) ? ram_rdata : '0;
    assign mem_dout_oe = core_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    cpu_rst_n_q <= 1'b0;
                    if (ld_acc) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ld_last) begin
                            state_q <= ST_RUN;
                        end
                    end else if (ptr_q == DEPTH_W) begin
                        // RAM full without ld_last: start the image anyway.
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cpu_rst_n_q <= 1'b1;
                    if (STP_flag) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    cpu_rst_n_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign state_o   = state_q;
    assign ld_count  = ptr_q;

endmodule

// File: tb/tb_mu0_mem_sys.sv
// tb_mu0_mem_sys: directed self-checking bench for mu0_mem_sys.
// Inputs change on the falling edge; outputs are sampled #1 later.
module tb_mu0_mem_sys;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          cpu_rst_n;
    logic [AW-1:0] addr;
    logic          MEMrq;
    logic          RnW;
    logic          STP_flag;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_dout_oe;
    logic [1:0]    state_o;
    logic [AW:0]   ld_count;
`ifdef MU0_MEM_WRITE_PROTECT_EN
    logic          wp_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mu0_mem_sys #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .cpu_rst_n   (cpu_rst_n),
        .addr        (addr),
        .MEMrq       (MEMrq),
        .RnW         (RnW),
        .STP_flag    (STP_flag),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_dout_oe (mem_dout_oe),
`ifdef MU0_MEM_WRITE_PROTECT_EN
        .wp_err      (wp_err),
`endif
        .state_o     (state_o),
        .ld_count    (ld_count)
    );

    task automatic idle_core();
        MEMrq    = 1'b0;
        RnW      = 1'b1;
        STP_flag = 1'b0;
        addr     = '0;
        mem_din  = '0;
    endtask

    // Reset; checks outputs during the reset cycle and right after it.
    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'h0;
        ld_last  = 1'b0;
        MEMrq    = 1'b1;
        RnW      = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ld_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ld_ready got=%b exp=0", ld_ready);
        end
        n_cmp++;
        if (state_o !== 2'd0 || ld_count !== 13'd0) begin
            n_err++;
            $display("FAIL rst_state got=%0d/%0d exp=0/0",
                     state_o, ld_count);
        end
        n_cmp++;
        if (cpu_rst_n !== 1'b0 || mem_dout_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rst_core got=%b/%b exp=0/0",
                     cpu_rst_n, mem_dout_oe);
        end
        @(negedge clk);
        rst      = 1'b0;
        ld_valid = 1'b0;
        idle_core();
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_ld_ready got=%b exp=1", ld_ready);
        end
    endtask

    // Streams a 3-word image; RUN follows the ld_last word.
    task automatic test_load3(input logic chk_rel);
        logic [DW-1:0] img [3];
        img[0] = 16'h1005;
        img[1] = 16'h2006;
        img[2] = 16'h7000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = (i == 2);
            MEMrq    = 1'b1;
            RnW      = 1'b1;
            #1;
            n_cmp++;
            if (ld_ready !== 1'b1 || mem_dout_oe !== 1'b0) begin
                n_err++;
                $display("FAIL load_word%0d rdy/oe got=%b/%b exp=1/0",
                         i, ld_ready, mem_dout_oe);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_o !== 2'd1 || ld_count !== 13'd3) begin
            n_err++;
            $display("FAIL load_done state/count got=%0d/%0d exp=1/3",
                     state_o, ld_count);
        end
        n_cmp++;
        if (cpu_rst_n !== 1'b0 || ld_ready !== 1'b0) begin
            n_err++;
            $display("FAIL run_entry rstn/rdy got=%b/%b exp=0/0",
                     cpu_rst_n, ld_ready);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        idle_core();
        @(posedge clk);
        #1;
        if (chk_rel) begin
            n_cmp++;
            if (cpu_rst_n !== 1'b1) begin
                n_err++;
                $display("FAIL cpu_release got=%b exp=1", cpu_rst_n);
            end
        end
    endtask

    task automatic test_read();
        logic [DW-1:0] exp_v [3];
        exp_v[0] = 16'h2006;
        exp_v[1] = 16'h1005;
        exp_v[2] = 16'h7000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            addr  = (i == 0) ? 12'd1 : (i == 1) ? 12'd0 : 12'd2;
            MEMrq = 1'b1;
            RnW   = 1'b1;
            #1;
            n_cmp++;
            if (mem_dout !== exp_v[i] || mem_dout_oe !== 1'b1) begin
                n_err++;
                $display("FAIL read%0d got=%h/%b exp=%h/1",
                         i, mem_dout, mem_dout_oe, exp_v[i]);
            end
        end
        @(negedge clk);
        MEMrq = 1'b0;
        #1;
        n_cmp++;
        if (mem_dout_oe !== 1'b0) begin
            n_err++;
            $display("FAIL no_req_oe got=%b exp=0", mem_dout_oe);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        addr    = 12'h100;
        MEMrq   = 1'b1;
        RnW     = 1'b0;
        mem_din = 16'hBEEF;
        #1;
        n_cmp++;
        if (mem_dout_oe !== 1'b0) begin
            n_err++;
            $display("FAIL write_oe got=%b exp=0", mem_dout_oe);
        end
        @(negedge clk);
        RnW     = 1'b1;
        mem_din = 16'h0;
        #1;
        n_cmp++;
        if (mem_dout !== 16'hBEEF || mem_dout_oe !== 1'b1) begin
            n_err++;
            $display("FAIL write_readback got=%h/%b exp=beef/1",
                     mem_dout, mem_dout_oe);
        end
        @(negedge clk);
        idle_core();
    endtask

    // STP with a same-cycle write to addr 5, then a dropped write in HALT.
    task automatic test_halt();
        @(negedge clk);
        STP_flag = 1'b1;
        MEMrq    = 1'b1;
        RnW      = 1'b0;
        addr     = 12'd5;
        mem_din  = 16'h1234;
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_o !== 2'd2) begin
            n_err++;
            $display("FAIL halt_state got=%0d exp=2", state_o);
        end
        @(negedge clk);
        STP_flag = 1'b0;
        addr     = 12'd0;
        RnW      = 1'b1;
        #1;
        n_cmp++;
        if (mem_dout_oe !== 1'b0 || cpu_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL halt_read oe/rstn got=%b/%b exp=0/1",
                     mem_dout_oe, cpu_rst_n);
        end
        @(negedge clk);
        addr    = 12'd5;
        RnW     = 1'b0;
        mem_din = 16'h5555;
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_o !== 2'd2) begin
            n_err++;
            $display("FAIL halt_sticky got=%0d exp=2", state_o);
        end
        @(negedge clk);
        idle_core();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_o !== 2'd0 || ld_count !== 13'd0 || cpu_rst_n !== 1'b0)
        begin
            n_err++;
            $display("FAIL halt_rst got=%0d/%0d/%b exp=0/0/0",
                     state_o, ld_count, cpu_rst_n);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reload keeps unloaded words: STP-cycle write kept, HALT write dropped.
    task automatic test_reload();
        test_load3(1'b0);
        @(negedge clk);
        addr  = 12'd5;
        MEMrq = 1'b1;
        RnW   = 1'b1;
        #1;
        n_cmp++;
        if (mem_dout !== 16'h1234) begin
            n_err++;
            $display("FAIL reload_keep5 got=%h exp=1234", mem_dout);
        end
        @(negedge clk);
        addr = 12'h100;
        #1;
        n_cmp++;
        if (mem_dout !== 16'hBEEF) begin
            n_err++;
            $display("FAIL reload_keep100 got=%h exp=beef", mem_dout);
        end
        @(negedge clk);
        addr    = 12'd0;
        RnW     = 1'b0;
        mem_din = 16'hFFFF;
        @(negedge clk);
        RnW = 1'b1;
        #1;
`ifdef MU0_MEM_WRITE_PROTECT_EN
        n_cmp++;
        if (mem_dout !== 16'h1005 || wp_err !== 1'b1) begin
            n_err++;
            $display("FAIL wp_write got=%h/%b exp=1005/1",
                     mem_dout, wp_err);
        end
`else
        n_cmp++;
        if (mem_dout !== 16'hFFFF) begin
            n_err++;
            $display("FAIL unprot_write got=%h exp=ffff", mem_dout);
        end
`endif
        @(negedge clk);
        idle_core();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fill every word without ld_last; RUN one cycle after the last word.
    task automatic test_full_load();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_last  = 1'b0;
            ld_data  = DW'(i) ^ 16'hA5A5;
            if (i == DEPTH - 1) begin
                #1;
                n_cmp++;
                if (ld_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_last_rdy got=%b exp=1", ld_ready);
                end
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ld_ready !== 1'b0 || ld_count !== 13'd4096 || state_o !== 2'd0)
        begin
            n_err++;
            $display("FAIL full_stop got=%b/%0d/%0d exp=0/4096/0",
                     ld_ready, ld_count, state_o);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_o !== 2'd1 || ld_count !== 13'd4096) begin
            n_err++;
            $display("FAIL full_run got=%0d/%0d exp=1/4096",
                     state_o, ld_count);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        addr     = 12'hFFF;
        MEMrq    = 1'b1;
        RnW      = 1'b1;
        #1;
        n_cmp++;
        if (mem_dout !== 16'hAA5A) begin
            n_err++;
            $display("FAIL full_rd_fff got=%h exp=aa5a", mem_dout);
        end
        @(negedge clk);
        addr = 12'h000;
        #1;
        n_cmp++;
        if (mem_dout !== 16'hA5A5) begin
            n_err++;
            $display("FAIL full_rd_000 got=%h exp=a5a5", mem_dout);
        end
        @(negedge clk);
        idle_core();
    endtask

    initial begin
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        idle_core();
        test_reset();
        test_load3(1'b1);
        test_read();
        test_write();
        test_halt();
        test_reload();
        test_full_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mu0_mem_sys.md
Name: mu0_mem_sys

Overview:
- Memory subsystem that sits directly downstream of the mu0 core. It services the core's addr/MEMrq/RnW bus from a word-addressed RAM.
- It also owns a boot-load stream port. A program image is loaded into RAM while the core is held in reset; the core is then released, and the block tracks the core's STP halt.
- The top level instantiates it next to mu0 and joins the shared data bus through a tri-state buffer, using mem_dout/mem_dout_oe.

Parameters:
- AW, 12, address width; matches the mu0 addr bus.
- DW, 16, data word width.
- DEPTH, 4096, number of RAM words; must satisfy DEPTH <= 2**AW.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- ld_valid  input  1  boot stream word valid.
- ld_data  input  DW  boot stream word.
- ld_last  input  1  marks the final boot word.
- ld_ready  output  1  block can accept a boot word.
- cpu_rst_n  output  1  active-low reset to mu0; low holds the core in reset.
- addr  input  AW  core address.
- MEMrq  input  1  core memory request.
- RnW  input  1  1 = read, 0 = write.
- STP_flag  input  1  core halt indication.
- mem_din  input  DW  bus value (ACC) during core writes.
- mem_dout  output  DW  read data to the bus.
- mem_dout_oe  output  1  drive enable for mem_dout onto the bus.
- state_o  output  2  current FSM state.
- ld_count  output  AW+1  number of boot words accepted.

Behaviour:
- States (2-bit encoding): LOAD=0, RUN=1, HALT=2. Reset forces LOAD.
- Reset values: ld_count=0, load pointer=0, cpu_rst_n=0, mem_dout_oe=0, ld_ready=0 during the reset cycle.
- LOAD:
  - ld_ready=1 while the pointer is below DEPTH.
  - A word is accepted on a cycle where ld_valid&&ld_ready. It is written to RAM[ptr] at that edge, then ptr and ld_count increment.
  - Accepting the word that has ld_last=1 moves the FSM to RUN.
  - If ptr reaches DEPTH without ld_last: ld_ready drops to 0 and the FSM moves to RUN on the next cycle.
  - Core signals are ignored and cpu_rst_n=0.
- RUN:
  - cpu_rst_n=1 from the first RUN cycle. Core reset release is registered, so the core sees it one cycle after entry.
  - ld_ready=0.
  - Core read (MEMrq&&RnW): mem_dout=RAM[addr] combinationally, in the same cycle, with mem_dout_oe=1. This gives the zero wait states that mu0's single-cycle fetch/execute requires.
  - Core write (MEMrq&&!RnW): RAM[addr] <= mem_din at the clock edge; mem_dout_oe=0.
  - No request: mem_dout_oe=0 and mem_dout is don't-care. mem_dout_oe must never be 1 while RnW=0.
  - addr >= DEPTH: reads return 0; writes are dropped.
  - STP_flag=1 moves the FSM to HALT at the next edge. A request in that same cycle is still serviced.
- HALT:
  - cpu_rst_n stays 1. All core requests are ignored and mem_dout_oe=0.
  - Leaves HALT only on rst.
- RAM contents are not cleared by rst. A reload overwrites only the words that are loaded.
- Reset mid-LOAD: the pointer and count restart at 0, and a partially accepted image is discarded logically.
- Simultaneous ld_valid and a core request in LOAD: the core request is ignored.

Optional Feature:
- Macro: MU0_MEM_WRITE_PROTECT_EN.
- With the macro defined:
  - Addresses below ld_count (the loaded image) are read-only to the core.
  - A core write to such an address is dropped, and the sticky output wp_err (1 bit, reset 0) is set.
  - wp_err clears only on rst.
- Without the macro: the wp_err port is absent and the core may write any address below DEPTH.

Decomposition:
- Package mu0_mem_pkg holds:
  - the state encoding constants ST_LOAD/ST_RUN/ST_HALT;
  - the default AW/DW/DEPTH localparams.
- One sub-module, mu0_ram: DEPTH x DW array with one synchronous write port and one asynchronous read port.
  - The write mux between the loader and the core stays in mu0_mem_sys.

Test Plan:
- Reset, then stream 3 words 16'h1005, 16'h2006, 16'h7000 with ld_last on the third -> ld_count=3; RUN on the next edge; cpu_rst_n rises one cycle later.
- In RUN, drive addr=1, MEMrq=1, RnW=1 -> same-cycle mem_dout=16'h2006, mem_dout_oe=1.
- Drive a write of mem_din=16'hBEEF to addr=12'h100, then read it back -> 16'hBEEF; mem_dout_oe=0 during the write cycle.
- Assert STP_flag -> HALT; a subsequent read at addr=0 gives mem_dout_oe=0; assert rst -> LOAD, ld_count=0, cpu_rst_n=0.
- Hold ld_valid=1 without ld_last for DEPTH words -> ld_ready=0 after word 4096; RUN on the next cycle.
- With MU0_MEM_WRITE_PROTECT_EN defined, write 16'hFFFF to addr=0 after a 3-word load -> RAM[0] stays 16'h1005; wp_err=1.
